// File: rtl/mux32_arbiter_pkg.sv
// Shared types and constants for the 32-requester round-robin arbiter.
package mux32_arbiter_pkg;

  localparam int unsigned NUM_REQ = 32;
  localparam int unsigned SEL_W   = 5;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/mux32_arbiter_mux32.sv
// 32:1 data mux, N bits per input; input i lives at in_data[i*N +: N].
module mux32
  import mux32_arbiter_pkg::*;
#(
  parameter int unsigned N = 1
) (
  input  logic [NUM_REQ*N-1:0] in_data,
  input  logic [SEL_W-1:0]     sel,
  output logic [N-1:0]         out_data
);

  assign out_data = in_data[sel*N +: N];

endmodule

// File: rtl/mux32_arbiter.sv
// Round-robin arbiter over 32 requesters with lock-extended bursts and a muxed output beat.
// Optional stall watchdog enabled by defining MUX32_ARBITER_TIMEOUT_EN.
module mux32_arbiter
  import mux32_arbiter_pkg::*;
#(
  parameter int unsigned N       = 1,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   lock,
  input  logic [NUM_REQ*N-1:0] in_data,
  output logic [NUM_REQ-1:0]   grant,
  output logic [SEL_W-1:0]     select,
  output logic [N-1:0]         out_data,
  output logic                 out_valid,
  input  logic                 out_ready
`ifdef MUX32_ARBITER_TIMEOUT_EN
  ,
  output logic                 timeout
`endif
);

  state_t               r_state, w_state_nxt;
  logic [SEL_W-1:0]     r_ptr, w_ptr_nxt;
  logic [SEL_W-1:0]     r_select, w_select_nxt;
  logic [NUM_REQ-1:0]   r_grant, w_grant_nxt;
  logic                 r_out_valid, w_valid_nxt;
  logic [SEL_W-1:0]     w_winner;
  logic                 w_found;
  logic                 w_hs;
  logic                 w_expire;

  assign w_hs = r_out_valid && out_ready;

  // First set request at or above r_ptr, wrapping 31 -> 0.
  always_comb begin
    logic [SEL_W-1:0] idx;
    w_winner = '0;
    w_found  = 1'b0;
    idx      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = r_ptr + SEL_W'(k);
      if (!w_found && req[idx]) begin
        w_winner = idx;
        w_found  = 1'b1;
      end
    end
  end

`ifdef MUX32_ARBITER_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [CNT_W-1:0] r_stall, w_stall_nxt;
  logic             r_timeout;

  assign w_expire = (r_state == BUSY) && r_out_valid && !out_ready &&
                    (r_stall == CNT_W'(TIMEOUT - 1));

  // Consecutive stall cycles; cleared by handshake, expiry and any non-BUSY cycle.
  always_comb begin
    w_stall_nxt = r_stall;
    if ((r_state != BUSY) || w_hs || w_expire) begin
      w_stall_nxt = '0;
    end else if (!out_ready) begin
      w_stall_nxt = r_stall + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall   <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_stall   <= w_stall_nxt;
      r_timeout <= w_expire;
    end
  end

  assign timeout = r_timeout;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^32'(TIMEOUT);
  assign w_expire         = 1'b0;
`endif

  // Next-state and registered outputs.
  always_comb begin
    w_state_nxt  = r_state;
    w_ptr_nxt    = r_ptr;
    w_select_nxt = r_select;
    w_grant_nxt  = r_grant;
    w_valid_nxt  = r_out_valid;
    case (r_state)
      IDLE: begin
        w_grant_nxt = '0;
        w_valid_nxt = 1'b0;
        if (w_found) begin
          w_state_nxt  = BUSY;
          w_select_nxt = w_winner;
          w_grant_nxt  = NUM_REQ'(1) << w_winner;
          w_valid_nxt  = 1'b1;
        end
      end
      BUSY: begin
        if ((w_hs && !(lock[r_select] && req[r_select])) || w_expire) begin
          w_state_nxt = IDLE;
          w_ptr_nxt   = r_select + SEL_W'(1);
          w_grant_nxt = '0;
          w_valid_nxt = 1'b0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_select    <= '0;
      r_grant     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_select    <= w_select_nxt;
      r_grant     <= w_grant_nxt;
      r_out_valid <= w_valid_nxt;
    end
  end

  assign grant     = r_grant;
  assign select    = r_select;
  assign out_valid = r_out_valid;

  mux32 #(.N(N)) u_mux32 (
    .in_data  (in_data),
    .sel      (r_select),
    .out_data (out_data)
  );

endmodule

// File: tb/tb_mux32_arbiter.sv
// Directed-vector bench for mux32_arbiter (N=8, TIMEOUT=4); covers the watchdog when MUX32_ARBITER_TIMEOUT_EN is defined.
module tb_mux32_arbiter;

  localparam int unsigned N  = 8;
  localparam int unsigned TO = 4;

  logic            clk;
  logic            rst;
  logic [31:0]     req;
  logic [31:0]     lock;
  logic [32*N-1:0] in_data;
  logic [31:0]     grant;
  logic [4:0]      select;
  logic [N-1:0]    out_data;
  logic            out_valid;
  logic            out_ready;
`ifdef MUX32_ARBITER_TIMEOUT_EN
  logic            timeout;
`endif

  int n_checks = 0;
  int n_errors = 0;

  mux32_arbiter #(.N(N), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .lock      (lock),
    .in_data   (in_data),
    .grant     (grant),
    .select    (select),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef MUX32_ARBITER_TIMEOUT_EN
    ,
    .timeout   (timeout)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    req       = '0;
    lock      = '0;
    out_ready = 1'b0;
    for (int i = 0; i < 32; i++) in_data[i*N +: N] = N'(i);
    in_data[5*N +: N] = 8'hA5;
    #12;
    check("rst_grant", grant, 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_select", 32'(select), 32'h0);
    rst = 1'b0;

    // Stalled beat from requester 5 holds grant and data.
    req = 32'h0000_0020;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("stall5_grant", grant, 32'h20);
      check("stall5_valid", 32'(out_valid), 32'h1);
      check("stall5_data", 32'(out_data), 32'hA5);
    end
    check("stall5_select", 32'(select), 32'd5);
    out_ready = 1'b1;
    req       = '0;
    tick();
    check("rel5_grant", grant, 32'h0);
    check("rel5_valid", 32'(out_valid), 32'h0);
    check("idle_select_hold", 32'(select), 32'd5);
    check("idle_data", 32'(out_data), 32'hA5);

    // Locked burst from 9 (ptr=6), then wrap to 2.
    req  = 32'h0000_0204;
    lock = 32'h0000_0200;
    for (int b = 0; b < 4; b++) begin
      tick();
      check("lock9_grant", grant, 32'h200);
      check("lock9_valid", 32'(out_valid), 32'h1);
    end
    lock = '0;
    tick();
    check("lock9_bubble", grant, 32'h0);
    tick();
    check("wrap2_grant", grant, 32'h4);
    check("wrap2_select", 32'(select), 32'd2);
    req = '0;
    tick();
    check("rel2_grant", grant, 32'h0);

    // Requester 12 drops its request while stalled.
    out_ready = 1'b0;
    req       = 32'h0000_1000;
    tick();
    check("g12_grant", grant, 32'h1000);
    req = '0;
    for (int c = 0; c < 2; c++) begin
      tick();
      check("drop12_grant", grant, 32'h1000);
      check("drop12_valid", 32'(out_valid), 32'h1);
      check("drop12_data", 32'(out_data), 32'h0C);
    end
    out_ready = 1'b1;
    tick();
    check("rel12_grant", grant, 32'h0);
    check("rel12_valid", 32'(out_valid), 32'h0);

    // Async reset mid-BUSY on requester 7 (ptr=13 wraps to 7).
    out_ready = 1'b0;
    req       = 32'h0000_0080;
    tick();
    check("g7_select", 32'(select), 32'd7);
    check("g7_grant", grant, 32'h80);
    req = '0;
    #3;
    rst = 1'b1;
    #1;
    check("arst_grant", grant, 32'h0);
    check("arst_valid", 32'(out_valid), 32'h0);
    check("arst_select", 32'(select), 32'h0);
    #1;
    rst       = 1'b0;
    req       = 32'h0000_0008;
    out_ready = 1'b1;
    tick();
    check("post_rst_g3", grant, 32'h8);
    req = '0;
    tick();
    check("post_rst_idle", grant, 32'h0);

    // All requesting: 0..31 then wrap to 0, one idle cycle between grants.
    do_reset();
    req = 32'hFFFF_FFFF;
    for (int i = 0; i <= 32; i++) begin
      tick();
      check("rr_grant", grant, 32'h1 << (i % 32));
      check("rr_select", 32'(select), 32'(i % 32));
      tick();
      check("rr_gap", grant, 32'h0);
      check("rr_gap_valid", 32'(out_valid), 32'h0);
    end
    req = '0;

`ifdef MUX32_ARBITER_TIMEOUT_EN
    // Watchdog: 4 stall cycles on requester 1, then resume search from 2.
    do_reset();
    out_ready = 1'b0;
    req       = 32'h0000_0002;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("to_wait_grant", grant, 32'h2);
      check("to_wait_pulse", 32'(timeout), 32'h0);
    end
    tick();
    check("to_pulse", 32'(timeout), 32'h1);
    check("to_grant", grant, 32'h0);
    check("to_valid", 32'(out_valid), 32'h0);
    req = 32'h0000_000B;
    tick();
    check("to_next_grant", grant, 32'h8);
    check("to_pulse_clr", 32'(timeout), 32'h0);
    req = '0;
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mux32_arbiter.md
MUX32_ARBITER -- requirements
Module: mux32_arbiter

Interface
REQ-001 Parameter N, default 1, data width per requester in bits.
REQ-002 Parameter TIMEOUT, default 16, stall-cycle limit; used only under REQ-024.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req  input  32  request per requester; bit i = requester i.
REQ-006 lock  input  32  bit i high = requester i keeps grant for further beats.
REQ-007 in_data  input  32*N  packed requester data; requester i at bits [i*N +: N].
REQ-008 grant  output  32  one-hot current grant, or all-zero.
REQ-009 select  output  5  registered index of granted requester.
REQ-010 out_data  output  N  in_data slice chosen by select, via the mux.
REQ-011 out_valid  output  1  beat available on out_data.
REQ-012 out_ready  input  1  downstream accepts beat when high with out_valid.

Function
REQ-013 FSM states: IDLE, BUSY.
REQ-014 IDLE with req nonzero: winner = first set req bit searching upward from ptr with wrap 31->0; next cycle BUSY, select=winner, grant=1<<winner, out_valid=1.
REQ-015 Latency: req sampled at edge k -> grant/out_valid visible after edge k+1.
REQ-016 IDLE with req all-zero: remain IDLE, grant=0, out_valid=0, select holds.
REQ-017 BUSY: out_valid=1, grant and select constant until handshake (out_valid && out_ready).
REQ-018 Handshake with lock[select] && req[select]: stay BUSY, same select, no bubble.
REQ-019 Handshake otherwise: ptr = (select+1) mod 32 (5-bit wrap), go IDLE; one idle cycle between grants.
REQ-020 req[select] dropping in BUSY without handshake: grant and out_valid held until handshake.
REQ-021 out_data is combinational from in_data and registered select; in IDLE it shows requester select's data, out_valid=0.
REQ-022 Requester 31 granted, released -> ptr=0; all 32 requesting -> grants 0,1,...,31,0 in order.

Reset
REQ-023 On rst high, immediately regardless of clk, including mid-BUSY: state=IDLE, ptr=0, select=0, grant=0, out_valid=0, timeout=0; pending beat discarded.

Configuration
REQ-024 Macro MUX32_ARBITER_TIMEOUT_EN defined: output port timeout (1 bit) exists; BUSY with out_valid high and out_ready low for TIMEOUT consecutive cycles -> timeout pulses high one cycle, grant dropped, ptr=(select+1) mod 32, IDLE.
REQ-025 Stall counter clears on every handshake and every IDLE entry.
REQ-026 Macro undefined: no timeout port, no counter; BUSY waits indefinitely for out_ready.

Structure
REQ-027 Shared package mux32_arbiter_pkg holds state enum (IDLE, BUSY) and constant NUM_REQ=32, SEL_W=5.
REQ-028 Output datapath reuses existing mux32 as sole sub-module, parameter N, fed by 32 slices of in_data, select = registered select.
REQ-029 Round-robin search is combinational logic local to this module; no second sub-module.

Verification
REQ-030 Reset mid-BUSY (select=7): assert rst without clk -> grant=0, out_valid=0, select=0 immediately; after release, req[3] -> grant[3] next edge.
REQ-031 req=32'hFFFF_FFFF, out_ready=1, lock=0: grants 0,1,...,31,0 each separated by one IDLE cycle.
REQ-032 N=8, req[5]=1, in_data slice 5=8'hA5, out_ready=0 for 4 cycles: out_valid stays 1, out_data=8'hA5, grant=32'h20 throughout.
REQ-033 lock[9]=1, req[9]=1, req[2]=1, 3 handshakes then lock[9]=0: 4 back-to-back beats from 9, then IDLE, then grant 2 (wrap).
REQ-034 Macro defined, TIMEOUT=4, req[1]=1, out_ready=0: timeout pulses exactly once after 4 stall cycles, grant=0, next winner searched from ptr=2.
REQ-035 req[12] dropped while BUSY on 12 with out_ready=0: grant[12] and out_valid held until out_ready=1, then IDLE.
